// File: rtl/texture_loader.sv
// rtl/texture_loader.sv - writes a runtime texel byte stream into the wall-texture RAM
// Address layout {~side, col, row} matches the texture lookup; row advances fastest.
module texture_loader #(
  parameter int CHANNEL_BITS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        start_side,
  input  logic                        load_both,
  input  logic                        abort,
  input  logic                        in_valid,
  input  logic [7:0]                  in_data,
  output logic                        in_ready,
  output logic                        wr_en,
  output logic [12:0]                 wr_addr,
  output logic [CHANNEL_BITS*3-1:0]   wr_data,
  output logic                        busy,
  output logic                        done
);

  localparam int TW = CHANNEL_BITS * 3;

  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  state_t          state_q;
  logic            side_q;
  logic            two_pass_q;
  logic [5:0]      col_q;
  logic [5:0]      row_q;
  logic            wr_en_q;
  logic [12:0]     wr_addr_q;
  logic [TW-1:0]   wr_data_q;
  logic            busy_q;
  logic            done_q;

  logic            accept;
  logic            pass_end;
  logic [5:0]      row_d;
  logic [5:0]      col_d;
  logic            unused_in_bits;

  assign in_ready       = (state_q == LOAD) && !abort;
  assign accept         = in_valid && in_ready;
  assign row_d          = row_q + 6'd1;
  assign col_d          = col_q + 6'd1;
  assign pass_end       = (row_q == 6'd63) && (col_q == 6'd63);
  assign unused_in_bits = ^in_data[7:TW];

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      side_q     <= 1'b0;
      two_pass_q <= 1'b0;
      col_q      <= 6'd0;
      row_q      <= 6'd0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 13'd0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            side_q     <= start_side;
            col_q      <= 6'd0;
            row_q      <= 6'd0;
            two_pass_q <= load_both;
          end
        end
        LOAD: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (accept) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= {~side_q, col_q, row_q};
            wr_data_q <= in_data[TW-1:0];
            row_q     <= row_d;
            if (row_q == 6'd63) begin
              col_q <= col_d;
            end
            // Second pass starts on the very next byte; no bubble at the side switch.
            if (pass_end) begin
              if (two_pass_q) begin
                side_q     <= ~side_q;
                two_pass_q <= 1'b0;
              end else begin
                state_q <= FINISH;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end
        end
        FINISH: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_texture_loader.sv
// tb/tb_texture_loader.sv - randomized self-checking bench for texture_loader
// Reference model tracks load progress as a texel index and derives address/data arithmetically.
module tb_texture_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        start_side;
  logic        load_both;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [12:0] wr_addr;
  logic [5:0]  wr_data;
  logic        busy;
  logic        done;

  texture_loader #(.CHANNEL_BITS(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_side (start_side),
    .load_both  (load_both),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: 0 idle, 1 loading, 2 the one completion cycle
  int   phase = 0;
  int   m_count;
  int   m_total;
  logic m_s0;

  logic        e_wr_en;
  logic [12:0] e_addr;
  logic [5:0]  e_data;
  logic        e_done;
  logic        e_busy;

  int          n_writes;
  int          n_done;
  logic [12:0] first_addr;
  logic [12:0] last_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic ss, input logic lb, input logic ab,
                      input logic v, input logic [7:0] d, input logic rst);
    logic acc;
    logic side;
    start      = st;
    start_side = ss;
    load_both  = lb;
    abort      = ab;
    in_valid   = v;
    in_data    = d;
    reset      = rst;
    #1;
    check("in_ready", in_ready, (phase == 1) && !ab);
    acc     = v && (phase == 1) && !ab;
    e_wr_en = 1'b0;
    e_done  = 1'b0;
    if (rst) begin
      phase  = 0;
      e_addr = '0;
      e_data = '0;
    end else begin
      case (phase)
        0: if (st) begin
          phase   = 1;
          m_count = 0;
          m_total = lb ? 8192 : 4096;
          m_s0    = ss;
        end
        1: if (ab) begin
          phase = 0;
        end else if (acc) begin
          side    = (m_count < 4096) ? m_s0 : !m_s0;
          e_wr_en = 1'b1;
          e_addr  = 13'((side ? 0 : 4096) + (m_count % 4096));
          e_data  = 6'(d & 8'h3F);
          m_count++;
          if (m_count == m_total) begin
            phase  = 2;
            e_done = 1'b1;
          end
        end
        default: phase = 0;
      endcase
    end
    e_busy = (phase == 1);
    @(posedge clk);
    #1;
    check("wr_en", wr_en, e_wr_en);
    check("done", done, e_done);
    check("busy", busy, e_busy);
    check("wr_addr", wr_addr, e_addr);
    check("wr_data", wr_data, e_data);
    if (wr_en) begin
      if (n_writes == 0) first_addr = wr_addr;
      last_addr = wr_addr;
      n_writes++;
    end
    if (done) n_done++;
  endtask

  task automatic run_load(input logic ss, input logic lb, input int duty, input logic ff,
                          input int abort_at, input int reset_at, input int start_at,
                          input int exp_writes, input int exp_dones);
    int cyc;
    logic v;
    logic [7:0] d;
    n_writes = 0;
    n_done   = 0;
    step(1'b1, ss, lb, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc = 0;
    while (phase != 0 && cyc < 30000) begin
      v = ($urandom_range(99) < duty);
      d = ff ? 8'hFF : 8'($urandom);
      step((m_count == start_at), 1'b1, 1'b1, (m_count == abort_at), v, d,
           (m_count == reset_at));
      cyc++;
    end
    check("timeout", (cyc >= 30000), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0);
    check("write_count", n_writes, exp_writes);
    check("done_count", n_done, exp_dones);
  endtask

  initial begin
    start = 0; start_side = 0; load_both = 0; abort = 0;
    in_valid = 0; in_data = 0; reset = 1;
    e_addr = '0; e_data = '0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);

    // reset after 100 accepts
    run_load(1'b0, 1'b0, 100, 1'b0, -1, 100, -1, 100, 0);
    check("reset_first", first_addr, 13'h1000);
    check("reset_last", last_addr, 13'h1063);

    run_load(1'b0, 1'b0, 100, 1'b0, -1, -1, -1, 4096, 1);
    check("single_first", first_addr, 13'h1000);
    check("single_last", last_addr, 13'h1FFF);

    run_load(1'b1, 1'b1, 100, 1'b0, -1, -1, -1, 8192, 1);
    check("both_first", first_addr, 13'h0000);
    check("both_last", last_addr, 13'h1FFF);

    run_load(1'b0, 1'b0, 50, 1'b1, -1, -1, -1, 4096, 1);

    run_load(1'b0, 1'b0, 100, 1'b0, 10, -1, -1, 10, 0);
    check("abort_last", last_addr, 13'h1009);

    run_load(1'b0, 1'b0, 70, 1'b0, -1, -1, 100, 4096, 1);
    check("restart_first", first_addr, 13'h1000);
    check("restart_last", last_addr, 13'h1FFF);

    run_load(1'b1, 1'b0, 60, 1'b0, -1, -1, -1, 4096, 1);
    check("side1_first", first_addr, 13'h0000);
    check("side1_last", last_addr, 13'h0FFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
